// File: rtl/hd_mix_decryptor_if.sv
// hd_mix_decryptor_if: ciphertext-in / plaintext-out handshake bundle for hd_mix_decryptor.
interface hd_mix_decryptor_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ciphertext;
  logic             anchor;
  logic [WIDTH-1:0] mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] plaintext;
  logic             err;
  modport master (
    output in_valid, ciphertext, anchor, mask, out_ready,
    input  in_ready, out_valid, plaintext, err
  );
  modport slave (
    input  in_valid, ciphertext, anchor, mask, out_ready,
    output in_ready, out_valid, plaintext, err
  );
endinterface

// File: rtl/hd_mix_decryptor.sv
// hd_mix_decryptor: masked bit-serial inverse of c = s ^ rotl(s,1), then p = s ^ key.
module hd_mix_decryptor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_key,
  input  logic [WIDTH-1:0] secret_key,
  output logic             busy,
  hd_mix_decryptor_if.slave bus
);
  localparam int KW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PRECHARGE, RECOVER, UNMASK, OUTPUT} st_t;
  st_t              st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d, cm_q, cm_d, mask_q, mask_d, key_q, key_d, pt_q, pt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             am_q, am_d, err_reg_q, err_reg_d, err_q, err_d;
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction
  // cm/am carry the masked mix relation, so recovery yields s ^ mask bit by bit
  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    cm_d      = cm_q;
    am_d      = am_q;
    mask_d    = mask_q;
    key_d     = key_q;
    k_d       = k_q;
    err_reg_d = err_reg_q;
    pt_d      = pt_q;
    err_d     = err_q;
    case (st_q)
      IDLE: begin
        if (load_key) key_d = secret_key;
        if (bus.in_valid) begin
          cm_d      = bus.ciphertext ^ bus.mask ^ rotl(bus.mask);
          am_d      = bus.anchor ^ bus.mask[0];
          mask_d    = bus.mask;
          err_reg_d = ^bus.ciphertext;
          st_d      = PRECHARGE;
        end
      end
      PRECHARGE: begin
        state_d = '0;
        k_d     = '0;
        st_d    = RECOVER;
      end
      RECOVER: begin
        state_d[k_q] = (k_q == '0) ? am_q : cm_q[k_q] ^ state_q[k_q - 1'b1];
        k_d          = k_q + 1'b1;
        st_d         = (k_q == KW'(WIDTH - 1)) ? UNMASK : RECOVER;
      end
      UNMASK: begin
        // key is removed before the mask so s itself never appears on a net or flop
        pt_d    = (state_q ^ key_q) ^ mask_q;
        state_d = '0;
        err_d   = err_reg_q;
        st_d    = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          err_d = 1'b0;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      state_q   <= '0;
      cm_q      <= '0;
      am_q      <= 1'b0;
      mask_q    <= '0;
      key_q     <= '0;
      k_q       <= '0;
      err_reg_q <= 1'b0;
      pt_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      state_q   <= state_d;
      cm_q      <= cm_d;
      am_q      <= am_d;
      mask_q    <= mask_d;
      key_q     <= key_d;
      k_q       <= k_d;
      err_reg_q <= err_reg_d;
      pt_q      <= pt_d;
      err_q     <= err_d;
    end
  end
  assign bus.in_ready  = (st_q == IDLE);
  assign bus.out_valid = (st_q == OUTPUT);
  assign bus.plaintext = pt_q;
  assign bus.err       = err_q;
  assign busy          = (st_q != IDLE);
endmodule
